// File: rtl/regfile_param.sv
// regfile_param: parameterised 2-read/1-write register file with r0 tied to zero,
// optional write-to-read bypass, an externally loaded register and a soft-clear sweep.
module regfile_param #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned EXT_REG = 0
) (
    input  logic                     clock,
    input  logic                     ctrl_reset,
    input  logic                     ctrl_writeEn,
    input  logic [$clog2(DEPTH)-1:0] ctrl_writeReg,
    input  logic [WIDTH-1:0]         data_writeReg,
    input  logic [$clog2(DEPTH)-1:0] ctrl_readRegA,
    input  logic [$clog2(DEPTH)-1:0] ctrl_readRegB,
    output logic [WIDTH-1:0]         data_readRegA,
    output logic [WIDTH-1:0]         data_readRegB,
    input  logic [WIDTH-1:0]         ext_val,
    input  logic                     ctrl_clear,
    output logic                     clear_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    // First and last registers the sweep visits; the external register is never swept.
    localparam int unsigned FIRST = (EXT_REG == 1) ? 2 : 1;
    localparam int unsigned LAST  = (EXT_REG == DEPTH - 1) ? DEPTH - 2 : DEPTH - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    state_e            state_q;
    logic [AW-1:0]     ptr_q;
    logic              busy_q;
    logic [WIDTH-1:0]  mem_q [DEPTH-1:1];

    logic              wr_en_c;
    logic              fwd_ok_c;
    logic [AW-1:0]     ptr_inc_c;
    logic [AW-1:0]     ptr_step_c;
    logic [WIDTH-1:0]  rd_a_c;
    logic [WIDTH-1:0]  rd_b_c;

    assign wr_en_c  = ctrl_writeEn && !busy_q
                      && (ctrl_writeReg != '0)
                      && (ctrl_writeReg != AW'(EXT_REG));
    assign fwd_ok_c = (BYPASS != 0) && ctrl_reset && wr_en_c;

    assign ptr_inc_c  = ptr_q + AW'(1);
    assign ptr_step_c = (ptr_inc_c == AW'(EXT_REG)) ? ptr_q + AW'(2) : ptr_inc_c;

    // Clear sequencer: walks the pointer over every storage register once.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q <= IDLE;
            ptr_q   <= AW'(1);
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctrl_clear) begin
                        state_q <= SWEEP;
                        ptr_q   <= AW'(FIRST);
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (ptr_q == AW'(LAST)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_step_c;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage for r1..r(DEPTH-1); sweep and processor writes are mutually exclusive via busy_q.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (i == EXT_REG) begin
                    mem_q[i] <= ext_val;
                end else if (busy_q && (ptr_q == AW'(i))) begin
                    mem_q[i] <= '0;
                end else if (wr_en_c && (ctrl_writeReg == AW'(i))) begin
                    mem_q[i] <= data_writeReg;
                end
            end
        end
    end

    // Read port A: address 0 falls through to zero.
    always_comb begin
        rd_a_c = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (ctrl_readRegA == AW'(i)) begin
                rd_a_c = mem_q[i];
            end
        end
        if (fwd_ok_c && (ctrl_readRegA == ctrl_writeReg)) begin
            rd_a_c = data_writeReg;
        end
    end

    // Read port B: same structure as port A.
    always_comb begin
        rd_b_c = '0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (ctrl_readRegB == AW'(i)) begin
                rd_b_c = mem_q[i];
            end
        end
        if (fwd_ok_c && (ctrl_readRegB == ctrl_writeReg)) begin
            rd_b_c = data_writeReg;
        end
    end

    assign data_readRegA = rd_a_c;
    assign data_readRegB = rd_b_c;
    assign clear_busy    = busy_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: a bypassing and a non-bypassing instance
// share stimulus and are compared every cycle against a queue-based behavioural model.
module tb_regfile_param;

    localparam int unsigned W   = 32;
    localparam int unsigned D   = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned EXT = 30;

    logic          clock         = 1'b0;
    logic          ctrl_reset    = 1'b1;
    logic          ctrl_writeEn  = 1'b0;
    logic [AW-1:0] ctrl_writeReg = '0;
    logic [W-1:0]  data_writeReg = '0;
    logic [AW-1:0] ctrl_readRegA = '0;
    logic [AW-1:0] ctrl_readRegB = '0;
    logic [W-1:0]  ext_val       = '0;
    logic          ctrl_clear    = 1'b0;

    logic [W-1:0]  rd_a1, rd_b1, rd_a0, rd_b0;
    logic          busy1, busy0;

    int            n_vec = 0;
    int            n_err = 0;

    logic [W-1:0]  m_mem [D];
    int            sweep_q [$];

    regfile_param #(.WIDTH(W), .DEPTH(D), .BYPASS(1), .EXT_REG(EXT)) dut_byp (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEn(ctrl_writeEn), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(rd_a1), .data_readRegB(rd_b1),
        .ext_val(ext_val), .ctrl_clear(ctrl_clear), .clear_busy(busy1)
    );

    regfile_param #(.WIDTH(W), .DEPTH(D), .BYPASS(0), .EXT_REG(EXT)) dut_nobyp (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEn(ctrl_writeEn), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(rd_a0), .data_readRegB(rd_b0),
        .ext_val(ext_val), .ctrl_clear(ctrl_clear), .clear_busy(busy0)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit m_we();
        return ctrl_writeEn && (sweep_q.size() == 0)
               && (ctrl_writeReg != 0) && (ctrl_writeReg != AW'(EXT));
    endfunction

    function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (!ctrl_reset || a == 0) return '0;
        if (byp && m_we() && a == ctrl_writeReg) return data_writeReg;
        return m_mem[a];
    endfunction

    // Behavioural model: a pending-clear queue stands in for the sweep.
    always @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            sweep_q.delete();
        end else begin
            if (m_we()) m_mem[ctrl_writeReg] = data_writeReg;
            if (sweep_q.size() != 0) begin
                m_mem[sweep_q.pop_front()] = '0;
            end else if (ctrl_clear) begin
                for (int r = 1; r < int'(D); r++)
                    if (r != int'(EXT)) sweep_q.push_back(r);
            end
            m_mem[EXT] = ext_val;
        end
    end

    always @(negedge clock) begin
        chk("cyc_rdA_byp",   rd_a1, exp_rd(ctrl_readRegA, 1'b1));
        chk("cyc_rdB_byp",   rd_b1, exp_rd(ctrl_readRegB, 1'b1));
        chk("cyc_rdA_nobyp", rd_a0, exp_rd(ctrl_readRegA, 1'b0));
        chk("cyc_rdB_nobyp", rd_b0, exp_rd(ctrl_readRegB, 1'b0));
        chk("cyc_busy_byp",   W'(busy1), W'(sweep_q.size() != 0));
        chk("cyc_busy_nobyp", W'(busy0), W'(sweep_q.size() != 0));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        foreach (m_mem[i]) m_mem[i] = '0;
        #2 ctrl_reset = 1'b0;
        tick();
        tick();
        ctrl_readRegA = 5; ctrl_readRegB = 0;
        #1;
        chk("reset_rdA", rd_a1, 32'h0);
        ctrl_reset = 1'b1;

        // Write r5, read it back next cycle.
        ctrl_writeEn = 1; ctrl_writeReg = 5; data_writeReg = 32'hDEADBEEF;
        tick();
        ctrl_writeEn = 0; ctrl_readRegA = 5; ctrl_readRegB = 0;
        #1;
        chk("wr_r5_A_byp",   rd_a1, 32'hDEADBEEF);
        chk("wr_r5_A_nobyp", rd_a0, 32'hDEADBEEF);
        chk("wr_r5_B_r0",    rd_b1, 32'h0);

        // r0 write is dropped, never forwarded.
        ctrl_writeEn = 1; ctrl_writeReg = 0; data_writeReg = 32'd7; ctrl_readRegA = 0;
        #1;
        chk("r0_same_cycle", rd_a1, 32'h0);
        tick();
        ctrl_writeEn = 0;
        #1;
        chk("r0_after_edge", rd_a1, 32'h0);

        // Bypass vs stored value.
        ctrl_writeEn = 1; ctrl_writeReg = 9; data_writeReg = 32'h1234; ctrl_readRegA = 9;
        #1;
        chk("bypass_r9_byp",   rd_a1, 32'h1234);
        chk("bypass_r9_nobyp", rd_a0, 32'h0);
        tick();
        ctrl_writeEn = 0;
        #1;
        chk("bypass_r9_nobyp_after", rd_a0, 32'h1234);

        // External register beats processor write and is not forwarded.
        ext_val = 32'd1; ctrl_writeEn = 1; ctrl_writeReg = 30; data_writeReg = 32'hFF;
        ctrl_readRegA = 30;
        #1;
        chk("ext_no_fwd", rd_a1, 32'h0);
        tick();
        ctrl_writeEn = 0;
        #1;
        chk("ext_load1", rd_a1, 32'd1);
        ext_val = 32'd2;
        #1;
        chk("ext_hold1", rd_a1, 32'd1);
        tick();
        chk("ext_load2", rd_a1, 32'd2);

        // Fill all registers, then sweep.
        for (int i = 1; i < int'(D); i++) begin
            ctrl_writeEn = 1; ctrl_writeReg = AW'(i); data_writeReg = 32'hA500_0000 | W'(i);
            tick();
        end
        ctrl_writeEn = 0;
        ctrl_readRegA = 31; ctrl_readRegB = 3;
        #1;
        chk("fill_r31", rd_a1, 32'hA500_001F);
        chk("fill_r3",  rd_b1, 32'hA500_0003);
        ctrl_clear = 1;
        tick();
        ctrl_clear = 0;
        cnt = 0;
        while (busy1 && cnt < 100) begin
            cnt++;
            ctrl_writeEn  = (cnt == 5);
            ctrl_writeReg = 3; data_writeReg = 32'h5555;
            ctrl_clear    = (cnt == 8);
            tick();
        end
        ctrl_writeEn = 0; ctrl_clear = 0;
        chk("sweep_len", W'(cnt), 32'd30);
        #1;
        chk("sweep_done_busy", W'(busy1), 32'd0);
        for (int a = 0; a < int'(D); a++) begin
            ctrl_readRegA = AW'(a); ctrl_readRegB = AW'(31 - a);
            #1;
            chk("post_sweep_A", rd_a1, (a == int'(EXT)) ? 32'd2 : 32'd0);
            chk("post_sweep_A_nobyp", rd_a0, (a == int'(EXT)) ? 32'd2 : 32'd0);
        end

        // Reset in the middle of a sweep.
        for (int i = 1; i < int'(D); i++) begin
            ctrl_writeEn = 1; ctrl_writeReg = AW'(i); data_writeReg = 32'h0F00_0000 | W'(i);
            tick();
        end
        ctrl_writeEn = 0;
        ctrl_clear = 1;
        tick();
        ctrl_clear = 0;
        repeat (10) tick();
        chk("mid_sweep_busy", W'(busy1), 32'd1);
        ctrl_reset = 1'b0;
        #1;
        chk("rst_mid_busy", W'(busy1), 32'd0);
        for (int a = 1; a < int'(D); a += 10) begin
            ctrl_readRegA = AW'(a); ctrl_readRegB = 31;
            #1;
            chk("rst_mid_rdA", rd_a1, 32'h0);
            chk("rst_mid_rdB", rd_b0, 32'h0);
        end
        tick();
        ctrl_reset = 1'b1;
        ctrl_writeEn = 1; ctrl_writeReg = 2; data_writeReg = 32'hABC; ctrl_readRegA = 2;
        #1;
        chk("post_rst_r2_pre", rd_a0, 32'h0);
        tick();
        ctrl_writeEn = 0; ctrl_readRegB = 30;
        #1;
        chk("post_rst_r2_byp",   rd_a1, 32'hABC);
        chk("post_rst_r2_nobyp", rd_a0, 32'hABC);
        chk("post_rst_ext",      rd_b1, 32'd2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
